// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler 4-bit datapath slice.
// The ALU evaluation lives here as a function so it stays one pure expression of the opcode table.
package nibbler_pkg;

    localparam int DATA_W  = 4;
    localparam int INSTR_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_PASS_B = 3'b010,
        ALU_ADD    = 3'b011,
        ALU_NAND   = 3'b100
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic              carry;
        logic              zero;
    } alu_res_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] operand;
    } fetch_word_t;

    // Reserved opcodes (101-111) produce a zero result with carry clear.
    function automatic alu_res_t alu_eval(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [2:0]        op);
        logic [DATA_W:0] sum;
        alu_res_t        res;
        sum       = '0;
        res.out   = '0;
        res.carry = 1'b0;
        res.zero  = 1'b0;
        case (op)
            ALU_PASS_A: res.out = a;
            ALU_SUB: begin
                // Two's-complement subtract: carry set means no borrow (a >= b).
                sum       = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                res.out   = sum[DATA_W-1:0];
                res.carry = sum[DATA_W];
            end
            ALU_PASS_B: res.out = b;
            ALU_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                res.out   = sum[DATA_W-1:0];
                res.carry = sum[DATA_W];
            end
            ALU_NAND: res.out = ~(a & b);
            default:  res.out = '0;
        endcase
        res.zero = (res.out == '0);
        return res;
    endfunction

endpackage

// File: rtl/nibbler_datapath_if.sv
// Control and result bundle between the Nibbler datapath and its ROM/decoder neighbours.
// master = decoder/fetch side driving controls; slave = the datapath itself.
interface nibbler_datapath_if;
    import nibbler_pkg::*;

    logic               fetch_en;
    logic [INSTR_W-1:0] program_byte;
    logic               load_a;
    logic [2:0]         alu_op;
    logic [DATA_W-1:0]  b;

    logic [DATA_W-1:0]  instr;
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  alu_out;
    logic               carry;
    logic               zero;

    modport master (
        output fetch_en, program_byte, load_a, alu_op, b,
        input  instr, operand, acc, alu_out, carry, zero
    );

    modport slave (
        input  fetch_en, program_byte, load_a, alu_op, b,
        output instr, operand, acc, alu_out, carry, zero
    );

endinterface

// File: rtl/nibbler_alu.sv
// Combinational 4-bit ALU: zero latency, flags derived from the truncated result.
module nibbler_alu
    import nibbler_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry,
    output logic              zero
);

    alu_res_t res;

    always_comb begin
        res     = alu_eval(a, b, alu_op);
        alu_out = res.out;
        carry   = res.carry;
        zero    = res.zero;
    end

endmodule

// File: rtl/nibbler_datapath.sv
// Nibbler datapath slice: fetch latch, accumulator and ALU.
// The acc -> ALU -> acc loop is broken by the accumulator register.
module nibbler_datapath
    import nibbler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    nibbler_datapath_if.slave   bus
);

    fetch_word_t       fetch_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              alu_zero;

    nibbler_alu u_alu (
        .a       (acc_q),
        .b       (bus.b),
        .alu_op  (bus.alu_op),
        .alu_out (alu_out),
        .carry   (alu_carry),
        .zero    (alu_zero)
    );

    // Reset wins over both load strobes; the two strobes are otherwise independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= '0;
            acc_q   <= '0;
        end else begin
            if (bus.fetch_en)
                fetch_q <= fetch_word_t'(bus.program_byte);
            if (bus.load_a)
                acc_q <= alu_out;
        end
    end

    assign bus.instr   = fetch_q.instr;
    assign bus.operand = fetch_q.operand;
    assign bus.acc     = acc_q;
    assign bus.alu_out = alu_out;
    assign bus.carry   = alu_carry;
    assign bus.zero    = alu_zero;

endmodule

// File: tb/tb_nibbler_datapath.sv
// Directed bench for nibbler_datapath: expected observations are queued, then popped and compared.
module tb_nibbler_datapath;

    typedef struct packed {
        logic [3:0] instr;
        logic [3:0] operand;
        logic [3:0] acc;
        logic [3:0] alu_out;
        logic       carry;
        logic       zero;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t  exp_q[$];
    string tag_q[$];

    nibbler_datapath_if dp_if();

    nibbler_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic fe, input logic [7:0] pb, input logic la,
                         input logic [2:0] op, input logic [3:0] bv);
        dp_if.fetch_en     = fe;
        dp_if.program_byte = pb;
        dp_if.load_a       = la;
        dp_if.alu_op       = op;
        dp_if.b            = bv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] i, input logic [3:0] o,
                        input logic [3:0] a, input logic [3:0] r, input logic c, input logic z);
        exp_t e;
        e = '{instr: i, operand: o, acc: a, alu_out: r, carry: c, zero: z};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [3:0] got, input logic [3:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, want);
        end
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "instr",   dp_if.instr,          e.instr);
        cmp(t, "operand", dp_if.operand,        e.operand);
        cmp(t, "acc",     dp_if.acc,            e.acc);
        cmp(t, "alu_out", dp_if.alu_out,        e.alu_out);
        cmp(t, "carry",   {3'b0, dp_if.carry},  {3'b0, e.carry});
        cmp(t, "zero",    {3'b0, dp_if.zero},   {3'b0, e.zero});
    endtask

    task automatic expect_now(input string tag, input logic [3:0] i, input logic [3:0] o,
                              input logic [3:0] a, input logic [3:0] r, input logic c, input logic z);
        push(tag, i, o, a, r, c, z);
        pop_check();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b1, 8'hA5, 1'b1, 3'b000, 4'h0);
        step();
        expect_now("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

        reset = 1'b0;
        drive(1'b1, 8'h3C, 1'b0, 3'b000, 4'h0);
        step();
        expect_now("fetch", 4'h3, 4'hC, 4'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 8'hFF, 1'b0, 3'b000, 4'h0);
        step();
        expect_now("fetch_hold", 4'h3, 4'hC, 4'h0, 4'h0, 1'b0, 1'b1);

        drive(1'b0, 8'hFF, 1'b1, 3'b010, 4'h7);
        expect_now("pass_b", 4'h3, 4'hC, 4'h0, 4'h7, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'hFF, 1'b0, 3'b011, 4'h9);
        expect_now("add_wrap", 4'h3, 4'hC, 4'h7, 4'h0, 1'b1, 1'b1);
        dp_if.load_a = 1'b1;
        step();
        dp_if.load_a = 1'b0;
        expect_now("add_load", 4'h3, 4'hC, 4'h0, 4'h9, 1'b0, 1'b0);

        drive(1'b0, 8'hFF, 1'b1, 3'b010, 4'h5);
        step();
        drive(1'b0, 8'hFF, 1'b0, 3'b001, 4'h5);
        expect_now("sub_eq", 4'h3, 4'hC, 4'h5, 4'h0, 1'b1, 1'b1);
        dp_if.b = 4'h6;
        expect_now("sub_borrow", 4'h3, 4'hC, 4'h5, 4'hF, 1'b0, 1'b0);
        dp_if.b = 4'h2;
        expect_now("sub_pos", 4'h3, 4'hC, 4'h5, 4'h3, 1'b1, 1'b0);

        drive(1'b0, 8'hFF, 1'b1, 3'b010, 4'hF);
        step();
        drive(1'b0, 8'hFF, 1'b0, 3'b100, 4'hF);
        expect_now("nand_ff", 4'h3, 4'hC, 4'hF, 4'h0, 1'b0, 1'b1);
        dp_if.alu_op = 3'b011;
        dp_if.b      = 4'h1;
        expect_now("add_f_1", 4'h3, 4'hC, 4'hF, 4'h0, 1'b1, 1'b1);

        drive(1'b0, 8'hFF, 1'b1, 3'b010, 4'hA);
        step();
        drive(1'b0, 8'hFF, 1'b0, 3'b100, 4'hC);
        expect_now("nand_ac", 4'h3, 4'hC, 4'hA, 4'h7, 1'b0, 1'b0);
        dp_if.alu_op = 3'b110;
        expect_now("rsvd_110", 4'h3, 4'hC, 4'hA, 4'h0, 1'b0, 1'b1);
        dp_if.alu_op = 3'b101;
        expect_now("rsvd_101", 4'h3, 4'hC, 4'hA, 4'h0, 1'b0, 1'b1);
        dp_if.alu_op = 3'b111;
        expect_now("rsvd_111", 4'h3, 4'hC, 4'hA, 4'h0, 1'b0, 1'b1);
        dp_if.alu_op = 3'b000;
        expect_now("pass_a", 4'h3, 4'hC, 4'hA, 4'hA, 1'b0, 1'b0);

        // Accumulator must hold across edges while load_a is low.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'hFF, 1'b0, 3'b010, 4'(i * 5));
            step();
            expect_now("acc_hold", 4'h3, 4'hC, 4'hA, 4'(i * 5), 1'b0, (i == 0));
        end

        drive(1'b0, 8'hFF, 1'b1, 3'b010, 4'h0);
        step();
        drive(1'b0, 8'hFF, 1'b0, 3'b001, 4'h1);
        expect_now("sub_0_1", 4'h3, 4'hC, 4'h0, 4'hF, 1'b0, 1'b0);

        // Fetch and accumulator load on the same edge.
        drive(1'b1, 8'h5A, 1'b1, 3'b010, 4'h9);
        step();
        drive(1'b0, 8'h00, 1'b0, 3'b011, 4'h3);
        expect_now("fetch_and_load", 4'h5, 4'hA, 4'h9, 4'hC, 1'b0, 1'b0);

        reset = 1'b1;
        drive(1'b1, 8'h77, 1'b1, 3'b010, 4'h3);
        step();
        reset = 1'b0;
        drive(1'b0, 8'h77, 1'b0, 3'b010, 4'h3);
        expect_now("reset_priority", 4'h0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
